// File: rtl/mem_access_unit.sv
// Load/store unit between a core request port and a byte-addressed SRAM that moves 4 bytes per access.
// Sub-word stores are read-modify-write so that the neighbouring bytes are written back unchanged.
module mem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, RD, RD_CAP, RMW_RD, RMW_CAP, WR, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                we_q, we_d;
  logic                uns_q, uns_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                req_bad;
  logic [DATA_W-1:0]   lane_mask;
  logic                ld_sign;
  logic [DATA_W-1:0]   ld_ext;
  logic [DATA_W-1:0]   st_merge;

  assign req_bad = (req_size == 2'b11) ||
                   ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  // The addressed bytes always sit in the low lanes of the SRAM word.
  always_comb begin
    case (size_q)
      SZ_BYTE: lane_mask = DATA_W'(8'hFF);
      SZ_HALF: lane_mask = DATA_W'(16'hFFFF);
      default: lane_mask = '1;
    endcase
  end

  assign ld_sign  = (size_q == SZ_BYTE) ? mem_rdata[7] : mem_rdata[15];
  assign ld_ext   = (mem_rdata & lane_mask) | ((ld_sign && !uns_q) ? ~lane_mask : '0);
  assign st_merge = (mem_rdata & ~lane_mask) | (wdata_q & lane_mask);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_en_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          if (req_bad) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (!req_we) begin
            state_d    = RD;
            mem_en_d   = 1'b1;
            mem_addr_d = req_addr;
          end else if (req_size == SZ_WORD) begin
            state_d     = WR;
            mem_en_d    = 1'b1;
            mem_wr_d    = 1'b1;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = RMW_RD;
            mem_en_d   = 1'b1;
            mem_addr_d = req_addr;
          end
        end
      end
      RD:     state_d = RD_CAP;
      RMW_RD: state_d = RMW_CAP;
      RMW_CAP: begin
        state_d     = WR;
        mem_en_d    = 1'b1;
        mem_wr_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = st_merge;
      end
      // Stores complete with zero data so resp_rdata never leaks a stale load.
      RD_CAP, WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = we_q ? '0 : ld_ext;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Gating with rst keeps an in-flight write from reaching the SRAM during the reset cycle.
  assign mem_enable = mem_en_q && !rst;
  assign mem_wr     = mem_wr_q && !rst;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array reference memory predicts every response,
// a separate monitor compares responses, latency and SRAM traffic as they appear.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, mem_enable, mem_wr;
  logic [31:0] resp_rdata, mem_wdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;

  mem_access_unit #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: byte array, 4 little-endian bytes per access, read data registered, 0 when idle.
  logic [7:0]  sram [0:65535];
  int          sram_writes = 0;
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = 16'h0;
  logic [7:0]  pl_data = 8'h0;
  always @(posedge clk) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    if (mem_enable && mem_wr) begin
      for (int i = 0; i < 4; i++) sram[mem_addr + 16'(i)] <= mem_wdata[8*i +: 8];
      sram_writes <= sram_writes + 1;
    end
    if (mem_enable && !mem_wr)
      mem_rdata <= {sram[mem_addr + 16'd3], sram[mem_addr + 16'd2], sram[mem_addr + 16'd1], sram[mem_addr]};
    else
      mem_rdata <= 32'h0;
  end

  int vectors = 0;
  int miscompares = 0;
  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    bit          chk_rdata;
    bit          err;
    int          nrd;
    int          nwr;
    bit          we;
    logic [1:0]  sz;
    logic [15:0] addr;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: plain byte-array semantics, updated when a request is accepted.
  logic [7:0] ref_mem [0:255];
  function automatic exp_t model(input bit we, input logic [1:0] sz, input bit uns,
                                 input logic [15:0] a, input logic [31:0] wd, input int acc);
    exp_t e;
    int nbytes;
    logic [31:0] v;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.we = we; e.sz = sz; e.addr = a;
    e.err = (sz == 2'd3) || ((int'(a) % nbytes) != 0);
    e.rdata = 32'h0; e.chk_rdata = !we || e.err; e.nrd = 0; e.nwr = 0;
    v = 32'h0;
    if (e.err) begin
      e.cyc = acc + 1;
    end else if (!we) begin
      for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_mem[8'(a + 16'(i))];
      if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | ~((32'd1 << (8*nbytes)) - 32'd1);
      e.rdata = v; e.cyc = acc + 3; e.nrd = 1;
    end else begin
      for (int i = 0; i < nbytes; i++) ref_mem[8'(a + 16'(i))] = wd[8*i +: 8];
      e.cyc = acc + ((nbytes == 4) ? 2 : 4);
      e.nwr = 1;
      e.nrd = (nbytes == 4) ? 0 : 1;
    end
    return e;
  endfunction

  // Monitor: samples just after the falling edge, when inputs and outputs are both settled.
  int          n_rd = 0, n_wr = 0, n_resp = 0;
  bit          hold_known = 1'b1;
  bit          hold_err = 1'b0;
  logic [31:0] hold_rdata = 32'h0;
  exp_t        me;
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      check("enable_in_reset", 64'({mem_enable, mem_wr}), 64'd0);
      n_rd = 0; n_wr = 0; hold_known = 1'b1; hold_err = 1'b0; hold_rdata = 32'h0;
    end else begin
      if (mem_enable) begin
        if (mem_wr) n_wr++; else n_rd++;
      end else begin
        check("idle_bus_zero", 64'({mem_wr, mem_addr, mem_wdata}), 64'd0);
      end
      if (resp_valid) begin
        check("ready_low_in_resp", 64'(req_ready), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
          hold_known = 1'b0;
        end else begin
          me = exp_q.pop_front();
          n_resp++;
          $display("resp %0d cyc=%0d we=%0b size=%0d addr=0x%04h rdata=0x%08h err=%0b",
                   n_resp, cyc, me.we, me.sz, me.addr, resp_rdata, resp_err);
          check("resp_cycle", 64'(cyc), 64'(me.cyc));
          check("resp_err", 64'(resp_err), 64'(me.err));
          if (me.chk_rdata) check("resp_rdata", 64'(resp_rdata), 64'(me.rdata));
          check("sram_reads", 64'(n_rd), 64'(me.nrd));
          check("sram_writes", 64'(n_wr), 64'(me.nwr));
          hold_known = me.chk_rdata; hold_rdata = me.rdata; hold_err = me.err;
        end
        n_rd = 0; n_wr = 0;
      end else begin
        check("hold_err", 64'(resp_err), 64'(hold_err));
        if (hold_known) check("hold_rdata", 64'(resp_rdata), 64'(hold_rdata));
      end
    end
  end

  int prev_acc = 0, prev_lat = 0;
  bit prev_kept = 1'b0;

  // Called on a falling edge; returns on a falling edge after the request is accepted.
  task automatic send(input bit we, input logic [1:0] sz, input bit uns,
                      input logic [15:0] a, input logic [31:0] wd, input bit keep);
    int waited;
    exp_t e;
    waited = 0;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0; prev_kept = 1'b0;
      return;
    end
    e = model(we, sz, uns, a, wd, cyc);
    exp_q.push_back(e);
    if (prev_kept) check("b2b_gap", 64'(cyc - prev_acc), 64'(prev_lat + 1));
    prev_acc = cyc; prev_lat = e.cyc - cyc; prev_kept = keep;
    @(negedge clk);
    if (!keep) begin
      req_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Accept a request, then assert reset 'at' cycles after the accept cycle.
  task automatic abort_at(input bit we, input logic [1:0] sz, input logic [15:0] a,
                          input logic [31:0] wd, input int at);
    int waited;
    int wr_before;
    waited = 0;
    req_we = we; req_size = sz; req_unsigned = 1'b0; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("abort_accept", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (at - 1) @(negedge clk);
    wr_before = sram_writes;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ready_after_abort", 64'(req_ready), 64'd1);
    check("no_write_on_abort", 64'(sram_writes), 64'(wr_before));
    prev_kept = 1'b0;
  endtask

  initial begin
    bit          we, uns;
    logic [1:0]  sz;
    logic [15:0] a;
    int          r, diffs;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ref_mem[i] = 8'($urandom);
      pl_en = 1'b1; pl_addr = 16'(i); pl_data = ref_mem[i];
    end
    @(negedge clk);
    pl_en = 1'b0;
    rst = 1'b0;
    check("ready_after_reset", 64'(req_ready), 64'd1);
    check("rdata_after_reset", 64'({resp_valid, resp_err, resp_rdata}), 64'd0);

    send(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 1'b0);
    send(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 1'b0);
    send(1'b1, 2'd0, 1'b0, 16'h0011, 32'h000000A5, 1'b0);
    send(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 1'b0);
    send(1'b1, 2'd0, 1'b0, 16'h0013, 32'h00000080, 1'b0);
    send(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0, 1'b0);
    send(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0, 1'b0);
    send(1'b1, 2'd1, 1'b0, 16'h0020, 32'h00008001, 1'b0);
    send(1'b0, 2'd1, 1'b0, 16'h0020, 32'h0, 1'b0);
    send(1'b0, 2'd1, 1'b1, 16'h0020, 32'h0, 1'b0);
    send(1'b0, 2'd1, 1'b0, 16'h0021, 32'h0, 1'b0);
    send(1'b1, 2'd2, 1'b0, 16'h0022, 32'h12345678, 1'b0);
    send(1'b0, 2'd3, 1'b0, 16'h0024, 32'h0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a = 16'($urandom_range(0, 240));
      if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2'd1) ? 16'h1 : (sz == 2'd0) ? 16'h0 : 16'h3);
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      send(we, sz, uns, a, $urandom, 1'($urandom_range(0, 1)));
    end

    for (int n = 0; n < 12; n++) begin
      sz = 2'($urandom_range(0, 2));
      a = 16'($urandom_range(0, 60)) << 2;
      send(n[0], sz, 1'($urandom_range(0, 1)), a, $urandom, n != 11);
    end

    abort_at(1'b1, 2'd0, 16'h0031, 32'h00000055, 2);
    send(1'b0, 2'd2, 1'b0, 16'h0030, 32'h0, 1'b0);
    abort_at(1'b1, 2'd2, 16'h0034, 32'hCAFEF00D, 1);
    send(1'b0, 2'd2, 1'b0, 16'h0034, 32'h0, 1'b0);
    abort_at(1'b0, 2'd2, 16'h0040, 32'h0, 1);
    send(1'b0, 2'd0, 1'b1, 16'h0041, 32'h0, 1'b0);

    repeat (10) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    diffs = 0;
    for (int i = 0; i < 256; i++) if (sram[i] !== ref_mem[i]) diffs++;
    check("mem_image", 64'(diffs), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
